// File: rtl/ovl_one_hot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and hold timeout.
// Optional sticky grant coverage vector under OVL_ONE_HOT_ARB_COV_EN.
module ovl_one_hot_rr_arbiter #(
  parameter int width     = 4,
  parameter int max_hold  = 16,
  parameter int idx_width = $clog2(width)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [width-1:0]     req,
  input  logic                 done,
  output logic [width-1:0]     gnt,
  output logic                 gnt_valid,
  output logic [idx_width-1:0] gnt_idx,
  output logic                 timeout
`ifdef OVL_ONE_HOT_ARB_COV_EN
  ,
  output logic [width-1:0]     one_hots_checked
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [15:0] HoldLast =
    (max_hold > 0) ? 16'(max_hold - 1) : 16'd0;

  state_t               state;
  state_t               state_nxt;
  logic [idx_width-1:0] ptr;
  logic [idx_width-1:0] ptr_nxt;
  logic [idx_width-1:0] sel_idx;
  logic                 sel_any;
  logic [15:0]          hold_cnt;
  logic                 release_hit;
  logic                 expire_hit;

  // First requester at or above ptr, searching upward modulo width
  always_comb begin
    logic [idx_width-1:0] cand;
    cand    = '0;
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = 0; i < width; i++) begin
      cand = idx_width'((int'(ptr) + i) % width);
      if (!sel_any && req[cand]) begin
        sel_any = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign release_hit = done | ~req[gnt_idx];
  assign expire_hit  = (max_hold != 0) && (hold_cnt == HoldLast);
  assign ptr_nxt     = (gnt_idx == idx_width'(width - 1))
                     ? '0 : gnt_idx + 1'b1;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sel_any) state_nxt = GRANT;
      GRANT:   if (release_hit || expire_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: a grant is live exactly while in GRANT
  always_comb begin
    gnt_valid = (state == GRANT);
  end

  // Grant, index, pointer, hold counter and timeout pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt      <= '0;
      gnt_idx  <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sel_any) begin
            gnt      <= width'(1) << sel_idx;
            gnt_idx  <= sel_idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_hit) begin
            gnt <= '0;
            ptr <= ptr_nxt;
          end else if (expire_hit) begin
            gnt     <= '0;
            timeout <= 1'b1;
            ptr     <= ptr_nxt;
          end else if (hold_cnt != 16'hFFFF) begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        default: gnt <= '0;
      endcase
    end
  end

`ifdef OVL_ONE_HOT_ARB_COV_EN
  // Sticky record of every requester that has held the grant
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) one_hots_checked <= '0;
    else          one_hots_checked <= one_hots_checked | gnt;
  end
`endif

endmodule

// File: tb/tb_ovl_one_hot_rr_arbiter.sv
// Bench for ovl_one_hot_rr_arbiter: directed + random vs. a queue-free
// owner/pointer model; instance a has max_hold=3, instance b has max_hold=0.
module tb_ovl_one_hot_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req_a = '0, req_b = '0;
  logic       done_a = 1'b0, done_b = 1'b0;
  logic [3:0] gnt_a, gnt_b;
  logic       val_a, val_b, to_a, to_b;
  logic [1:0] idx_a, idx_b;
`ifdef OVL_ONE_HOT_ARB_COV_EN
  logic [3:0] cov_a, cov_b;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ovl_one_hot_rr_arbiter #(.width(4), .max_hold(3)) u_a (
    .clk(clk), .reset_n(reset_n), .req(req_a), .done(done_a),
    .gnt(gnt_a), .gnt_valid(val_a), .gnt_idx(idx_a), .timeout(to_a)
`ifdef OVL_ONE_HOT_ARB_COV_EN
    , .one_hots_checked(cov_a)
`endif
  );

  ovl_one_hot_rr_arbiter #(.width(4), .max_hold(0)) u_b (
    .clk(clk), .reset_n(reset_n), .req(req_b), .done(done_b),
    .gnt(gnt_b), .gnt_valid(val_b), .gnt_idx(idx_b), .timeout(to_b)
`ifdef OVL_ONE_HOT_ARB_COV_EN
    , .one_hots_checked(cov_b)
`endif
  );

  typedef struct {
    int         owner;
    int         held;
    int         ptr;
    int         last;
    bit         to;
    logic [3:0] cov;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mreset();
    mdl_t r;
    r.owner = -1; r.held = 0; r.ptr = 0;
    r.last = 0; r.to = 0; r.cov = '0;
    return r;
  endfunction

  function automatic logic [3:0] egnt(mdl_t s);
    return (s.owner >= 0) ? (4'b0001 << s.owner) : 4'b0000;
  endfunction

  // One clock edge of the arbiter rules, written over owner/held counts
  function automatic mdl_t mstep(mdl_t s, logic [3:0] r, bit d, int mh);
    mdl_t n = s;
    n.to = 0;
    n.cov = s.cov | egnt(s);
    if (s.owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int c = (s.ptr + k) % 4;
        if (n.owner < 0 && r[c]) begin
          n.owner = c; n.last = c; n.held = 1;
        end
      end
    end else if (d || !r[s.owner]) begin
      n.ptr = (s.owner + 1) % 4;
      n.owner = -1;
    end else if (mh != 0 && s.held == mh) begin
      n.to = 1;
      n.ptr = (s.owner + 1) % 4;
      n.owner = -1;
    end else begin
      n.held = s.held + 1;
    end
    return n;
  endfunction

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    vectors++;
    assert (act === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ":a_gnt"}, 32'(gnt_a), 32'(egnt(ma)));
    chk({tag, ":a_val"}, 32'(val_a), 32'(ma.owner >= 0));
    chk({tag, ":a_idx"}, 32'(idx_a), 32'(ma.last));
    chk({tag, ":a_to"}, 32'(to_a), 32'(ma.to));
    chk({tag, ":a_1hot"}, 32'($onehot0(gnt_a)), 32'd1);
    chk({tag, ":b_gnt"}, 32'(gnt_b), 32'(egnt(mb)));
    chk({tag, ":b_val"}, 32'(val_b), 32'(mb.owner >= 0));
    chk({tag, ":b_idx"}, 32'(idx_b), 32'(mb.last));
    chk({tag, ":b_to"}, 32'(to_b), 32'(mb.to));
    chk({tag, ":b_1hot"}, 32'($onehot0(gnt_b)), 32'd1);
`ifdef OVL_ONE_HOT_ARB_COV_EN
    chk({tag, ":a_cov"}, 32'(cov_a), 32'(ma.cov));
    chk({tag, ":b_cov"}, 32'(cov_b), 32'(mb.cov));
`endif
  endtask

  task automatic step(string tag);
    @(posedge clk);
    ma = mstep(ma, req_a, done_a, 3);
    mb = mstep(mb, req_b, done_b, 0);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(string tag);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    ma = mreset();
    mb = mreset();
    check_all(tag);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    ma = mreset();
    mb = mreset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // basic grant then handoff to requester 2
    req_a = 4'b0101;
    step("basic_g0");
    chk("basic_first", 32'(gnt_a), 32'h1);
    done_a = 1'b1;
    step("basic_rel");
    done_a = 1'b0;
    step("basic_g2");
    chk("basic_second", 32'(gnt_a), 32'h4);
    chk("basic_idx", 32'(idx_a), 32'd2);

    // rotation and wrap with done on every grant
    do_reset("rot_rst");
    req_a = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      done_a = (ma.owner >= 0);
      step("rotate");
    end
    done_a = 1'b0;

    // timeout on a, no timeout on b over 100 cycles
    do_reset("to_rst");
    req_a = 4'b0001;
    req_b = 4'b0001;
    for (int i = 0; i < 100; i++) step("timeout");
    chk("b_held_100", 32'(gnt_b), 32'h1);
    req_b = 4'b0000;
    step("b_drop");

    // withdrawal by the owner
    do_reset("wd_rst");
    req_a = 4'b0010;
    step("wd_g");
    req_a = 4'b0000;
    step("wd_drop");
    chk("wd_clear", 32'(gnt_a), 32'h0);

    // done collides with the last hold cycle
    req_a = 4'b0001;
    step("col_idle");
    step("col_g");
    step("col_h2");
    done_a = 1'b1;
    step("col_rel");
    chk("col_no_to", 32'(to_a), 32'h0);
    done_a = 1'b0;
    req_a = 4'b0000;
    step("col_end");

    // asynchronous reset while requester 2 owns the grant
    req_a = 4'b0100;
    for (int i = 0; i < 4 && ma.owner != 2; i++) step("mid_acq");
    chk("mid_owner", 32'(gnt_a), 32'h4);
    do_reset("mid_rst");
    chk("mid_zero", 32'({gnt_a, val_a, idx_a}), 32'h0);
    step("mid_regrant");
    chk("mid_regrant_gnt", 32'(gnt_a), 32'h4);

    // coverage accumulates requesters 1 and 3
    do_reset("cov_rst");
    req_a = 4'b0010;
    step("cov_g1");
    done_a = 1'b1;
    step("cov_r1");
    done_a = 1'b0;
    req_a = 4'b1000;
    step("cov_g3");
    step("cov_h3");
    req_a = 4'b0000;
    step("cov_end");
    do_reset("cov_clr");

    // random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      req_a  = 4'($urandom_range(0, 15));
      req_b  = 4'($urandom_range(0, 15));
      done_a = ($urandom_range(0, 3) == 0);
      done_b = ($urandom_range(0, 3) == 0);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ovl_one_hot_rr_arbiter.md
# ovl_one_hot_rr_arbiter

Round-robin arbiter that shares one resource between `width` requesters. It drives a registered grant vector that is always one-hot or all-zero by construction, and this vector is the signal the team binds `assert_one_hot` to. Each grant is held until the owner releases it or a hold-timeout expires. The block sits in front of shared checker datapaths in the OVL bench and test harnesses.

## Interface
Parameters:
- `width`, 4, number of requesters; legal range 2..32.
- `max_hold`, 16, maximum number of cycles a grant may be held; 0 disables the timeout; legal range 0..65535.
- `idx_width`, `$clog2(width)`, width of `gnt_idx`; derived, do not override.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input `width`: per-requester request level.
- `done` input 1: release pulse from the current owner; ignored when no grant is active.
- `gnt` output `width`: registered grant; one-hot or zero.
- `gnt_valid` output 1: high when `gnt` is non-zero.
- `gnt_idx` output `idx_width`: binary index of the granted requester; holds its last value when `gnt_valid` is 0.
- `timeout` output 1: one-cycle pulse when a grant is revoked by the hold-timeout.
- `one_hots_checked` output `width`: sticky coverage vector; present only with `OVL_ONE_HOT_ARB_COV_EN`.

## Operation
- FSM states: IDLE and GRANT.
- IDLE:
  - If `req` is non-zero, select the first set bit at or above `ptr`, searching upward modulo `width`.
  - Load `gnt`, `gnt_idx` and `hold_cnt` = 0.
  - Go to GRANT.
  - If `req` is zero, stay in IDLE.
- GRANT, release: if `done` = 1, or `req[gnt_idx]` = 0, then:
  - clear `gnt`;
  - set `ptr` = (`gnt_idx` + 1) mod `width`;
  - go to IDLE.
- GRANT, timeout: else if `max_hold` != 0 and `hold_cnt` == `max_hold` − 1, then:
  - clear `gnt`;
  - pulse `timeout`;
  - advance `ptr` the same way;
  - go to IDLE.
- GRANT, otherwise: increment `hold_cnt`. It is 16 bits wide and never wraps, because the timeout fires first; with `max_hold` = 0 it saturates at 0xFFFF.
- Simultaneous release and timeout: release wins and `timeout` stays 0.
- Requests from non-owners during GRANT are ignored. No preemption.
- The pointer wraps: after `gnt_idx` = `width` − 1, `ptr` becomes 0.
- Reset values: `gnt` = 0, `gnt_valid` = 0, `gnt_idx` = 0, `timeout` = 0, `ptr` = 0, `hold_cnt` = 0, state IDLE, `one_hots_checked` = 0.

## Timing
- Grant latency is 1 cycle: `req` sampled in IDLE at edge N gives `gnt` valid after edge N.
- A release or timeout sampled at edge M clears `gnt` after edge M. The block always spends at least one cycle in IDLE, so back-to-back grants are separated by exactly one zero cycle. Consequently the minimum turnaround from a `done` sampled at edge M to the next grant is 2 edges (M and M+1), with the new grant visible after edge M+1.
- Grant duration:
  - A grant lasts at most `max_hold` cycles.
  - `timeout` is high in the same cycle in which `gnt` first reads 0.
  - With `max_hold` = 1, every grant lasts exactly 1 cycle unless released.
- Assertion of `reset_n` = 0 at any time, including mid-grant, clears all outputs immediately without waiting for a clock edge. The first grant can occur at the first edge after deassertion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `OVL_ONE_HOT_ARB_COV_EN` defined:
  - `one_hots_checked` is present.
  - On every edge where a grant is loaded, the granted bit is OR-ed into it. The bit is visible one cycle after `gnt` rises.
  - The vector is sticky and is cleared only by reset.
- Macro not defined:
  - The port and its register are omitted.
  - All other behaviour is identical.

## Test plan
- Basic grant: `width`=4, reset, `req`=4'b0101 held → `gnt`=0001 after first edge. After `done`, one zero cycle, then `gnt`=0100 with `gnt_idx`=2.
- Rotation and wrap: `req`=4'b1111 with `done` pulsed on every grant → `gnt` sequence 0001, 0010, 0100, 1000, 0001, with exactly one zero cycle between grants.
- Timeout: `max_hold`=3, `req`=0001 held, `done`=0 → `gnt` high exactly 3 cycles. `timeout` pulses with the drop, then `gnt`=0001 is regranted after one IDLE cycle. With `max_hold`=0, `gnt` stays high for 100 cycles and `timeout` stays 0.
- Request withdrawal and collision: owner drops `req` → `gnt` clears next edge. `done` in the same cycle as `hold_cnt` = `max_hold`−1 → `timeout` stays 0.
- Reset mid-grant: drive `reset_n`=0 between edges while `gnt`=0100 → `gnt`, `gnt_valid` and `gnt_idx` go to 0 immediately. After release with `req`=0100, `gnt`=0100 appears one edge later (`ptr` was reset to 0).
- Coverage (macro defined): grant requesters 1 then 3 → `one_hots_checked`=1010. Reset → `one_hots_checked`=0000. Throughout all scenarios, `gnt` is checked one-hot-or-zero every cycle.
